// File: rtl/rv_encoder.sv
// RV32I instruction encoder: turns a field-level request into a 32-bit word,
// substitutes a flagged NOP for illegal/out-of-range requests, buffers in a 2-entry FIFO.
module rv_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] stat_count,
  output logic [7:0]  stat_err_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [2:0] FMT_R      = 3'd0;
  localparam logic [2:0] FMT_I      = 3'd1;
  localparam logic [2:0] FMT_LOAD   = 3'd2;
  localparam logic [2:0] FMT_STORE  = 3'd3;
  localparam logic [2:0] FMT_BRANCH = 3'd4;
  localparam logic [2:0] FMT_JAL    = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        imm_i_ok;
  logic        imm_b_ok;
  logic        imm_j_ok;

  // An immediate fits when every bit above the field's sign bit matches it.
  assign imm_i_ok = (in_imm[31:11] == {21{in_imm[31]}});
  assign imm_b_ok = (in_imm[31:12] == {20{in_imm[31]}}) && !in_imm[0];
  assign imm_j_ok = (in_imm[31:20] == {12{in_imm[31]}}) && !in_imm[0];

  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b0;
    case (in_fmt)
      FMT_R:
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      FMT_I, FMT_LOAD:
        if (imm_i_ok)
          enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd,
                       (in_fmt == FMT_LOAD) ? OP_LOAD : OP_I};
        else
          enc_err = 1'b1;
      FMT_STORE:
        if (imm_i_ok)
          enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        else
          enc_err = 1'b1;
      FMT_BRANCH:
        if (imm_b_ok)
          enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], OP_BRANCH};
        else
          enc_err = 1'b1;
      FMT_JAL:
        if (imm_j_ok)
          enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
        else
          enc_err = 1'b1;
      default:
        enc_err = 1'b1;
    endcase
    if (enc_err)
      enc_instr = NOP;
  end

  logic [1:0][31:0] slot_instr_q, slot_instr_d;
  logic [1:0]       slot_err_q, slot_err_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [15:0]      stat_count_q, stat_count_d;
  logic [7:0]       stat_err_count_q, stat_err_count_d;
  logic             push;
  logic             pop;

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = ~count_q[1];
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    slot_instr_d     = slot_instr_q;
    slot_err_d       = slot_err_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    stat_count_d     = stat_count_q;
    stat_err_count_d = stat_err_count_q;
    if (push) begin
      slot_instr_d[wr_ptr_q] = enc_instr;
      slot_err_d[wr_ptr_q]   = enc_err;
      wr_ptr_d               = ~wr_ptr_q;
      stat_count_d           = stat_count_q + 16'd1;
      if (enc_err && (stat_err_count_q != 8'hFF))
        stat_err_count_d = stat_err_count_q + 8'd1;
    end
    if (pop)
      rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_instr_q     <= '0;
      slot_err_q       <= '0;
      rd_ptr_q         <= 1'b0;
      wr_ptr_q         <= 1'b0;
      count_q          <= 2'd0;
      stat_count_q     <= 16'd0;
      stat_err_count_q <= 8'd0;
    end else begin
      slot_instr_q     <= slot_instr_d;
      slot_err_q       <= slot_err_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      stat_count_q     <= stat_count_d;
      stat_err_count_q <= stat_err_count_d;
    end
  end

  assign out_instr      = out_valid ? slot_instr_q[rd_ptr_q] : NOP;
  assign out_err        = out_valid & slot_err_q[rd_ptr_q];
  assign stat_count     = stat_count_q;
  assign stat_err_count = stat_err_count_q;

endmodule

// File: tb/tb_rv_encoder.sv
// Self-checking bench for rv_encoder: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_rv_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] stat_count;
  logic [7:0]  stat_err_count;

  int checks = 0;
  int errors = 0;

  logic [32:0] refq[$];
  logic [15:0] refCount;
  logic [7:0]  refErr;

  always #5 clk = ~clk;

  rv_encoder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .stat_count(stat_count), .stat_err_count(stat_err_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference encoding: range rules as signed integer bounds, fields placed by shifts.
  function automatic logic [32:0] refEncode(input logic [2:0] fmt, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    longint v;
    bit ok;
    logic [31:0] w;
    logic [31:0] regs;
    v = longint'($signed(imm));
    regs = (32'(rs1) << 15) | (32'(f3) << 12);
    ok = 1'b1;
    w = 32'h13;
    case (fmt)
      3'd0: w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7) | 32'h33;
      3'd1, 3'd2: begin
        ok = (v >= -2048) && (v <= 2047);
        w = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7) | ((fmt == 3'd1) ? 32'h13 : 32'h03);
      end
      3'd3: begin
        ok = (v >= -2048) && (v <= 2047);
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs
            | ((imm & 32'h1F) << 7) | 32'h23;
      end
      3'd4: begin
        ok = (v >= -4096) && (v <= 4095) && (v % 2 == 0);
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
            | regs | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
      end
      3'd5: begin
        ok = (v >= -(64'sd1 << 20)) && (v < (64'sd1 << 20)) && (v % 2 == 0);
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
            | (32'(rd) << 7) | 32'h6F;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) return {32'h13, 1'b1};
    return {w, 1'b0};
  endfunction

  function automatic logic [31:0] randImm();
    int edges [16] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096,
                       -4098, 1048574, 1048576, -1048576, -1048578, 0, 1, -1};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'(edges[$urandom_range(0, 15)]);
      2:       return 32'(int'($urandom_range(0, 8191)) - 4096);
      default: return 32'(int'($urandom_range(0, 4194303)) - 2097152);
    endcase
  endfunction

  task automatic applyStimulus(input bit v, input logic [2:0] fmt, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm, input bit ordy);
    in_valid  = v;
    in_fmt    = fmt;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    out_ready = ordy;
  endtask

  task automatic compareAll(input string tag);
    logic [32:0] head;
    head = (refq.size() != 0) ? refq[0] : {32'h13, 1'b0};
    checkOutput({tag, ".in_ready"},  32'(in_ready),  32'(refq.size() < 2));
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(refq.size() != 0));
    checkOutput({tag, ".out_instr"}, out_instr,      head[32:1]);
    checkOutput({tag, ".out_err"},   32'(out_err),   32'(head[0]));
    checkOutput({tag, ".stat_cnt"},  32'(stat_count), 32'(refCount));
    checkOutput({tag, ".stat_err"},  32'(stat_err_count), 32'(refErr));
  endtask

  // One clock: model the handshake at the rising edge, then check on the falling edge.
  task automatic runCycle(input string tag);
    bit acc, pop;
    logic [32:0] e;
    @(posedge clk);
    if (!reset) begin
      acc = in_valid && (refq.size() < 2);
      pop = (refq.size() != 0) && out_ready;
      e = '0;
      if (acc) e = refEncode(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
      if (pop) void'(refq.pop_front());
      if (acc) begin
        refq.push_back(e);
        refCount++;
        if (e[0] && refErr != 8'hFF) refErr++;
      end
    end
    @(negedge clk);
    compareAll(tag);
  endtask

  task automatic clearModel();
    refq.delete();
    refCount = '0;
    refErr   = '0;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    clearModel();
    applyStimulus(1'b1, 3'd0, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b1);
    runCycle("reset");
    checkOutput("reset.out_instr", out_instr, 32'h13);
    reset = 1'b0;
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1);
  endtask

  logic [31:0] wa, wb, wc, lastWord;
  logic [32:0] tmp;

  initial begin
    reset = 1'b1;
    clearModel();
    applyStimulus(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
    @(negedge clk);
    compareAll("por");
    resetDut();

    // Basic R encoding and one-cycle latency.
    applyStimulus(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b1);
    runCycle("r");
    checkOutput("r.word", out_instr, 32'h003100B3);
    checkOutput("r.count", 32'(stat_count), 32'd1);

    resetDut();
    applyStimulus(1'b1, 3'd1, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1);
    runCycle("i_neg");
    checkOutput("i_neg.word", out_instr, 32'hFFF00293);
    applyStimulus(1'b1, 3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b1);
    runCycle("branch");
    checkOutput("branch.word", out_instr, 32'h00208463);

    resetDut();
    applyStimulus(1'b1, 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b1);
    runCycle("jal_odd");
    checkOutput("jal_odd.word", out_instr, 32'h13);
    checkOutput("jal_odd.err", 32'(out_err), 32'd1);
    applyStimulus(1'b1, 3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1);
    runCycle("i_big");
    checkOutput("i_big.err", 32'(out_err), 32'd1);
    checkOutput("i_big.errcnt", 32'(stat_err_count), 32'd2);
    checkOutput("i_big.count", 32'(stat_count), 32'd2);

    // Backpressure: third request waits until the first word is popped.
    resetDut();
    tmp = refEncode(3'd0, 5'd1, 5'd4, 5'd7, 3'd0, 7'd0, 32'd0); wa = tmp[32:1];
    tmp = refEncode(3'd0, 5'd2, 5'd5, 5'd8, 3'd1, 7'd0, 32'd0); wb = tmp[32:1];
    tmp = refEncode(3'd0, 5'd3, 5'd6, 5'd9, 3'd2, 7'd32, 32'd0); wc = tmp[32:1];
    applyStimulus(1'b1, 3'd0, 5'd1, 5'd4, 5'd7, 3'd0, 7'd0, 32'd0, 1'b0);
    runCycle("bp1");
    applyStimulus(1'b1, 3'd0, 5'd2, 5'd5, 5'd8, 3'd1, 7'd0, 32'd0, 1'b0);
    runCycle("bp2");
    checkOutput("bp2.in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 3'd0, 5'd3, 5'd6, 5'd9, 3'd2, 7'd32, 32'd0, 1'b0);
    runCycle("bp3");
    checkOutput("bp3.head", out_instr, wa);
    checkOutput("bp3.count", 32'(stat_count), 32'd2);
    out_ready = 1'b1;
    runCycle("bp_pop1");
    checkOutput("bp_pop1.head", out_instr, wb);
    checkOutput("bp_pop1.in_ready", 32'(in_ready), 32'd1);
    runCycle("bp_acc3");
    checkOutput("bp_acc3.head", out_instr, wc);
    checkOutput("bp_acc3.count", 32'(stat_count), 32'd3);
    in_valid = 1'b0;
    runCycle("bp_drain");

    // Occupancy 1 with simultaneous push and pop.
    resetDut();
    applyStimulus(1'b1, 3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd100, 1'b1);
    tmp = refEncode(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd100);
    runCycle("pp_fill");
    lastWord = tmp[32:1];
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 3'd1, 5'(i + 2), 5'(i), 5'd0, 3'(i), 7'd0, 32'(i * 3), 1'b1);
      tmp = refEncode(3'd1, 5'(i + 2), 5'(i), 5'd0, 3'(i), 7'd0, 32'(i * 3));
      checkOutput("pp.head", out_instr, lastWord);
      runCycle("pp");
      checkOutput("pp.out_valid", 32'(out_valid), 32'd1);
      checkOutput("pp.in_ready", 32'(in_ready), 32'd1);
      lastWord = tmp[32:1];
    end
    in_valid = 1'b0;
    runCycle("pp_drain");

    // Asynchronous reset with two buffered words.
    resetDut();
    applyStimulus(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0);
    runCycle("ar1");
    runCycle("ar2");
    checkOutput("ar2.count", 32'(stat_count), 32'd2);
    #2;
    reset = 1'b1;
    clearModel();
    #1;
    compareAll("ar_async");
    runCycle("ar_hold");
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    runCycle("ar_release");
    checkOutput("ar_release.out_valid", 32'(out_valid), 32'd0);

    // Randomized traffic, X on data fields while idle.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0)
        applyStimulus(1'b1, 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
                      5'($urandom), 3'($urandom), 7'($urandom), randImm(),
                      1'($urandom_range(0, 2) != 0));
      else
        applyStimulus(1'b0, 'x, 'x, 'x, 'x, 'x, 'x, 'x, 1'($urandom_range(0, 1)));
      runCycle("rand");
    end

    // Error counter saturation.
    resetDut();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 3'd7, 5'($urandom), 5'($urandom), 5'($urandom), 3'd0, 7'd0,
                    $urandom, 1'b1);
      runCycle("sat");
    end
    checkOutput("sat.errcnt", 32'(stat_err_count), 32'hFF);
    checkOutput("sat.count", 32'(stat_count), 32'd300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_encoder.md
RV_ENCODER -- requirements
Module: rv_encoder

Interface
REQ-001 The module SHALL have these ports (name direction width meaning), clock and reset first:
  clk  in  1  clock; all state updates on rising edge.
  reset  in  1  reset, asynchronous, active-high.
  in_valid  in  1  encode request valid.
  in_ready  out  1  encoder can accept a request.
  in_fmt  in  3  0=R, 1=I(ALU), 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL, 6..7 illegal.
  in_rd, in_rs1, in_rs2  in  5 each  register fields.
  in_funct3  in  3  funct3 field.
  in_funct7  in  7  funct7 field (R only).
  in_imm  in  32  signed byte-offset/immediate, two's complement.
  out_valid  out  1  encoded word available.
  out_ready  in  1  consumer accepts word.
  out_instr  out  32  encoded RV32I instruction word.
  out_err  out  1  sideband: this word is an error substitute.
  stat_count  out  16  total accepted requests, wraps.
  stat_err_count  out  8  total error requests, saturates at 0xFF.

Function
REQ-002 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; no other edge consumes inputs.
REQ-003 Encoding SHALL be combinational from the inputs at acceptance; the resulting {out_instr,out_err} SHALL be pushed into a 2-entry FIFO on that edge.
REQ-004 R: {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
REQ-005 I: {imm[11:0], rs1, funct3, rd, 7'b0010011}; LOAD identical with opcode 7'b0000011.
REQ-006 STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}.
REQ-007 BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}.
REQ-008 JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}.
REQ-009 Range rules: I/LOAD/STORE require in_imm[31:11] all equal; BRANCH requires in_imm[31:12] all equal and in_imm[0]=0; JAL requires in_imm[31:20] all equal and in_imm[0]=0; R ignores in_imm.
REQ-010 On illegal in_fmt or range violation, the pushed entry SHALL be out_instr=32'h00000013 (NOP), out_err=1; otherwise out_err=0.
REQ-011 Latency: word accepted at edge N SHALL be visible with out_valid=1 in the cycle after edge N.
REQ-012 out_valid SHALL equal (FIFO occupancy != 0); out_instr/out_err SHALL show the head entry; out_instr SHALL be 32'h00000013 and out_err 0 when empty.
REQ-013 Head pops on a rising edge where out_valid=1 and out_ready=1.
REQ-014 in_ready SHALL equal (occupancy < 2), registered-state-derived only, with no combinational path from out_ready.
REQ-015 Simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order; push while full cannot occur (in_ready=0).
REQ-016 stat_count SHALL increment by 1 per accepted request, wrapping 0xFFFF->0x0000.
REQ-017 stat_err_count SHALL increment per accepted error request, holding at 0xFF.
REQ-018 Inputs SHALL be ignored when in_valid=0, including X on data fields.

Reset
REQ-019 While reset=1: occupancy=0, out_valid=0, in_ready=1, out_instr=32'h00000013, out_err=0, stat_count=0, stat_err_count=0.
REQ-020 Reset asserted mid-operation SHALL discard all buffered entries immediately (asynchronously); no accept or pop occurs on an edge while reset=1.

Verification
REQ-021 R fmt, rd=1, rs1=2, rs2=3, funct3=0, funct7=0 -> next cycle out_valid=1, out_instr=0x003100B3, out_err=0, stat_count=1.
REQ-022 I fmt, rd=5, rs1=0, funct3=0, imm=0xFFFFFFFF -> out_instr=0xFFF00293; BRANCH rs1=1, rs2=2, funct3=0, imm=8 -> out_instr=0x00208463.
REQ-023 JAL imm=3, then I imm=2048 -> both out_instr=0x00000013 with out_err=1, stat_err_count=2, stat_count=2.
REQ-024 out_ready=0, three back-to-back requests -> in_ready=0 after second accept, third held; out_ready=1 -> words emerge in order, third accepted the cycle after first pop.
REQ-025 Occupancy 1 with simultaneous push/pop for 10 cycles -> out_valid stays 1, in_ready stays 1, order preserved.
REQ-026 Two entries buffered, stat_count=2, assert reset between edges -> out_valid=0, in_ready=1, counters 0 immediately; no stale word after release.
